// File: rtl/baccarat_pkg.sv
// rtl/baccarat_pkg.sv - shared state encoding, card codes and card helpers for the baccarat deal controller
package baccarat_pkg;

    typedef enum logic [3:0] {
        S_P1,
        S_D1,
        S_P2,
        S_D2,
        S_EVAL,
        S_P3,
        S_B3,
        S_D3,
        S_DONE,
        S_CLR
    } state_t;

    localparam logic [3:0] CARD_NONE = 4'd0;
    localparam logic [3:0] CARD_ACE  = 4'd1;
    localparam logic [3:0] CARD_TEN  = 4'd10;
    localparam logic [3:0] CARD_KING = 4'd13;
    localparam logic [3:0] SCORE_MAX = 4'd9;

    // Baccarat point value of a card code: ace counts 1, pips count face value,
    // tens and court cards count 0; an empty slot or an illegal code counts 0.
    function automatic logic [3:0] card_value(input logic [3:0] code);
        logic [3:0] v;
        if (code == CARD_NONE || code > CARD_KING) begin
            v = 4'd0;
        end else if (code == CARD_ACE) begin
            v = 4'd1;
        end else if (code >= CARD_TEN) begin
            v = 4'd0;
        end else begin
            v = code;
        end
        return v;
    endfunction

    // Hand totals above 9 cannot come from a real scorer; clamp them so the
    // compares behave as if the total were 9.
    function automatic logic [3:0] sat_score(input logic [3:0] s);
        return (s > SCORE_MAX) ? SCORE_MAX : s;
    endfunction

endpackage

// File: rtl/banker_third_rule.sv
// rtl/banker_third_rule.sv - banker third-card draw table after the player has drawn
module banker_third_rule
    import baccarat_pkg::*;
(
    input  logic [3:0] dscore,
    input  logic [3:0] pvalue,
    output logic       draw
);

    // Draw decision indexed by the banker two-card total and the player's third-card value.
    always_comb begin
        draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (pvalue != 4'd8);
            4'd4:             draw = (pvalue >= 4'd2) && (pvalue <= 4'd7);
            4'd5:             draw = (pvalue >= 4'd4) && (pvalue <= 4'd7);
            4'd6:             draw = (pvalue >= 4'd6) && (pvalue <= 4'd7);
            default:          draw = 1'b0;
        endcase
    end

endmodule

// File: rtl/baccarat_deal_ctrl.sv
// rtl/baccarat_deal_ctrl.sv - sequencing FSM for one baccarat hand: card load strobes, draw rules, win lights
module baccarat_deal_ctrl
    import baccarat_pkg::*;
#(
    parameter logic [3:0] NATURAL_MIN  = 4'd8,
    parameter logic [3:0] PLAYER_STAND = 4'd6,
    parameter logic [3:0] BANKER_STAND = 4'd6
) (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic       deal_en,
    input  logic       new_hand,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       clr_hands,
    output logic       player_win_light,
    output logic       dealer_win_light
);

    state_t     state_q, state_d;
    logic       pwin_q, pwin_d;
    logic       dwin_q, dwin_d;
    logic [3:0] ps, ds, pv;
    logic       banker_draw;

    assign ps = sat_score(pscore);
    assign ds = sat_score(dscore);
    assign pv = card_value(pcard3);

    banker_third_rule u_banker_rule (
        .dscore (ds),
        .pvalue (pv),
        .draw   (banker_draw)
    );

    // State and win-light registers.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state_q <= S_P1;
            pwin_q  <= 1'b0;
            dwin_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pwin_q  <= pwin_d;
            dwin_q  <= dwin_d;
        end
    end

    // Next state, load decode and light updates; strobes are held low while reset is asserted.
    always_comb begin
        state_d     = state_q;
        pwin_d      = pwin_q;
        dwin_d      = dwin_q;
        load_pcard1 = 1'b0;
        load_pcard2 = 1'b0;
        load_pcard3 = 1'b0;
        load_dcard1 = 1'b0;
        load_dcard2 = 1'b0;
        load_dcard3 = 1'b0;
        clr_hands   = 1'b0;
        case (state_q)
            S_P1: if (deal_en) begin
                load_pcard1 = 1'b1;
                state_d     = S_D1;
            end
            S_D1: if (deal_en) begin
                load_dcard1 = 1'b1;
                state_d     = S_P2;
            end
            S_P2: if (deal_en) begin
                load_pcard2 = 1'b1;
                state_d     = S_D2;
            end
            S_D2: if (deal_en) begin
                load_dcard2 = 1'b1;
                state_d     = S_EVAL;
            end
            S_EVAL: if (deal_en) begin
                if (ps >= NATURAL_MIN || ds >= NATURAL_MIN) begin
                    state_d = S_DONE;
                end else if (ps < PLAYER_STAND) begin
                    state_d = S_P3;
                end else if (ds < BANKER_STAND) begin
                    state_d = S_D3;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_P3: if (deal_en) begin
                load_pcard3 = 1'b1;
                state_d     = S_B3;
            end
            S_B3: if (deal_en) begin
                state_d = banker_draw ? S_D3 : S_DONE;
            end
            S_D3: if (deal_en) begin
                load_dcard3 = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                pwin_d = (ps >= ds);
                dwin_d = (ds >= ps);
                if (new_hand) begin
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                clr_hands = 1'b1;
                pwin_d    = 1'b0;
                dwin_d    = 1'b0;
                state_d   = S_P1;
            end
            default: state_d = S_P1;
        endcase
        if (!resetb) begin
            load_pcard1 = 1'b0;
            load_pcard2 = 1'b0;
            load_pcard3 = 1'b0;
            load_dcard1 = 1'b0;
            load_dcard2 = 1'b0;
            load_dcard3 = 1'b0;
            clr_hands   = 1'b0;
        end
    end

    assign player_win_light = pwin_q && (state_q != S_CLR);
    assign dealer_win_light = dwin_q && (state_q != S_CLR);

endmodule

// File: tb/tb_baccarat_deal_ctrl.sv
// tb/tb_baccarat_deal_ctrl.sv - self-checking bench for baccarat_deal_ctrl and banker_third_rule
module tb_baccarat_deal_ctrl;

    logic       slow_clock = 1'b0;
    logic       resetb     = 1'b0;
    logic       deal_en    = 1'b0;
    logic       new_hand   = 1'b0;
    logic [3:0] pscore, dscore, pcard3;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       clr_hands, player_win_light, dealer_win_light;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [3:0] p1, p2, p3, d1, d2, d3;
        bit         ep3, ed3, epw, edw;
    } vec_t;

    vec_t vecs[9];

    logic [3:0] hp1, hp2, hp3, hd1, hd2, hd3;
    logic [3:0] rp1, rp2, rp3, rd1, rd2, rd3;
    int         cnt[6];
    int         multi_hot;

    logic [3:0] r_ds, r_v;
    logic       r_draw;

    always #5 slow_clock = ~slow_clock;

    baccarat_deal_ctrl dut (
        .slow_clock       (slow_clock),
        .resetb           (resetb),
        .deal_en          (deal_en),
        .new_hand         (new_hand),
        .pscore           (pscore),
        .dscore           (dscore),
        .pcard3           (pcard3),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .clr_hands        (clr_hands),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light)
    );

    banker_third_rule u_rule (
        .dscore (r_ds),
        .pvalue (r_v),
        .draw   (r_draw)
    );

    function automatic int val(input logic [3:0] c);
        return (c >= 4'd10) ? 0 : int'(c);
    endfunction

    // Card registers of the datapath
    always @(posedge slow_clock or negedge resetb) begin
        if (!resetb || clr_hands) begin
            rp1 <= 4'd0; rp2 <= 4'd0; rp3 <= 4'd0;
            rd1 <= 4'd0; rd2 <= 4'd0; rd3 <= 4'd0;
        end else begin
            if (load_pcard1) rp1 <= hp1;
            if (load_pcard2) rp2 <= hp2;
            if (load_pcard3) rp3 <= hp3;
            if (load_dcard1) rd1 <= hd1;
            if (load_dcard2) rd2 <= hd2;
            if (load_dcard3) rd3 <= hd3;
        end
    end

    assign pscore = 4'((val(rp1) + val(rp2) + val(rp3)) % 10);
    assign dscore = 4'((val(rd1) + val(rd2) + val(rd3)) % 10);
    assign pcard3 = rp3;

    // Strobe monitor: counts loads per card and flags cycles with more than one strobe
    always @(negedge slow_clock) begin
        if (resetb) begin
            int n;
            n = int'(load_pcard1) + int'(load_pcard2) + int'(load_pcard3)
              + int'(load_dcard1) + int'(load_dcard2) + int'(load_dcard3);
            if (n > 1) multi_hot++;
            if (load_pcard1) cnt[0]++;
            if (load_pcard2) cnt[1]++;
            if (load_dcard1) cnt[2]++;
            if (load_dcard2) cnt[3]++;
            if (load_pcard3) cnt[4]++;
            if (load_dcard3) cnt[5]++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge slow_clock);
        #1;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 6; i++) cnt[i] = 0;
        multi_hot = 0;
    endtask

    function automatic int strobe_sum();
        return int'(load_pcard1) + int'(load_pcard2) + int'(load_pcard3)
             + int'(load_dcard1) + int'(load_dcard2) + int'(load_dcard3);
    endfunction

    function automatic vec_t mk(input int p1, input int p2, input int p3,
                                input int d1, input int d2, input int d3,
                                input bit ep3, input bit ed3, input bit epw, input bit edw);
        vec_t v;
        v.p1 = 4'(p1); v.p2 = 4'(p2); v.p3 = 4'(p3);
        v.d1 = 4'(d1); v.d2 = 4'(d2); v.d3 = 4'(d3);
        v.ep3 = ep3; v.ed3 = ed3; v.epw = epw; v.edw = edw;
        return v;
    endfunction

    // Banker draw table as per-total bitmasks over the player's third-card value
    function automatic bit table_draw(input int dt, input int pv);
        logic [9:0] mask;
        case (dt)
            0, 1, 2: mask = 10'h3FF;
            3:       mask = 10'h2FF;
            4:       mask = 10'h0FC;
            5:       mask = 10'h0F0;
            6:       mask = 10'h0C0;
            default: mask = 10'h000;
        endcase
        return mask[pv];
    endfunction

    // Whole-hand outcome computed directly from the six dealt cards
    function automatic vec_t model(input vec_t h);
        vec_t r;
        int   pt, dt, pf, df;
        r  = h;
        pt = (val(h.p1) + val(h.p2)) % 10;
        dt = (val(h.d1) + val(h.d2)) % 10;
        r.ep3 = 1'b0;
        r.ed3 = 1'b0;
        if (pt < 8 && dt < 8) begin
            if (pt < 6) begin
                r.ep3 = 1'b1;
                r.ed3 = table_draw(dt, val(h.p3));
            end else begin
                r.ed3 = (dt < 6);
            end
        end
        pf = (pt + (r.ep3 ? val(h.p3) : 0)) % 10;
        df = (dt + (r.ed3 ? val(h.d3) : 0)) % 10;
        r.epw = (pf >= df);
        r.edw = (df >= pf);
        return r;
    endfunction

    task automatic load_hand(input vec_t v);
        hp1 = v.p1; hp2 = v.p2; hp3 = v.p3;
        hd1 = v.d1; hd2 = v.d2; hd3 = v.d3;
    endtask

    task automatic run_enabled(input int n, input bit rnd);
        int got = 0;
        int cyc = 0;
        bit en;
        while (got < n && cyc < 400) begin
            en = rnd ? bit'($urandom_range(0, 1)) : 1'b1;
            deal_en = en;
            tick();
            if (en) got++;
            cyc++;
        end
        deal_en = 1'b0;
        if (got < n) chk("run_bound", got, n);
    endtask

    task automatic check_hand(input string tag, input vec_t e);
        @(negedge slow_clock);
        chk({tag, ".pcard1"}, cnt[0], 1);
        chk({tag, ".pcard2"}, cnt[1], 1);
        chk({tag, ".dcard1"}, cnt[2], 1);
        chk({tag, ".dcard2"}, cnt[3], 1);
        chk({tag, ".pcard3"}, cnt[4], int'(e.ep3));
        chk({tag, ".dcard3"}, cnt[5], int'(e.ed3));
        chk({tag, ".pwin"}, int'(player_win_light), int'(e.epw));
        chk({tag, ".dwin"}, int'(dealer_win_light), int'(e.edw));
        chk({tag, ".onehot"}, multi_hot, 0);
        @(posedge slow_clock);
        #1;
    endtask

    task automatic new_hand_seq(input string tag, input bit en);
        new_hand = 1'b1;
        deal_en  = en;
        tick();
        new_hand = 1'b0;
        deal_en  = 1'b0;
        @(negedge slow_clock);
        chk({tag, ".clr"}, int'(clr_hands), 1);
        chk({tag, ".clr_lights"}, int'(player_win_light) + int'(dealer_win_light), 0);
        chk({tag, ".clr_loads"}, strobe_sum(), 0);
        tick();
        @(negedge slow_clock);
        chk({tag, ".clr_end"}, int'(clr_hands), 0);
        chk({tag, ".p1_lights"}, int'(player_win_light) + int'(dealer_win_light), 0);
        @(posedge slow_clock);
        #1;
    endtask

    task automatic play_hand(input string tag, input vec_t v, input bit rnd, input bit nh_en);
        load_hand(v);
        clear_counts();
        run_enabled(12, rnd);
        check_hand(tag, v);
        new_hand_seq(tag, nh_en);
    endtask

    initial begin
        vec_t v;
        vecs[0] = mk(4, 4, 9, 3, 2, 9,    0, 0, 1, 0);
        vecs[1] = mk(2, 3, 13, 1, 3, 5,   1, 0, 1, 0);
        vecs[2] = mk(2, 3, 7, 1, 3, 5,    1, 1, 0, 1);
        vecs[3] = mk(3, 4, 9, 2, 2, 3,    0, 1, 1, 1);
        vecs[4] = mk(3, 3, 9, 4, 3, 9,    0, 0, 0, 1);
        vecs[5] = mk(10, 11, 3, 12, 13, 6, 1, 1, 0, 1);
        vecs[6] = mk(1, 2, 9, 4, 5, 9,    0, 0, 0, 1);
        vecs[7] = mk(1, 1, 8, 2, 1, 9,    1, 0, 0, 1);
        vecs[8] = mk(10, 4, 5, 3, 4, 9,   1, 0, 1, 0);
        load_hand(vecs[0]);
        clear_counts();

        // Reset state, including strobes gated while reset is held with deal_en high
        tick();
        tick();
        deal_en = 1'b1;
        #1;
        chk("rst.strobes", strobe_sum() + int'(clr_hands), 0);
        chk("rst.lights", int'(player_win_light) + int'(dealer_win_light), 0);
        deal_en = 1'b0;
        tick();
        resetb = 1'b1;
        tick();
        chk("rst.idle", strobe_sum() + int'(clr_hands), 0);

        // Banker third-card table, every total against every player card value
        for (int d = 0; d < 10; d++) begin
            for (int p = 0; p < 10; p++) begin
                r_ds = 4'(d);
                r_v  = 4'(p);
                #1;
                chk($sformatf("rule.d%0d.v%0d", d, p), int'(r_draw), int'(table_draw(d, p)));
            end
        end

        // Directed hands from the vector table
        for (int i = 0; i < 9; i++) begin
            play_hand($sformatf("vec%0d", i), vecs[i], 1'b0, bit'(i % 2));
        end

        // Deal stalled in S_P2 for five cycles; new_hand there is ignored
        load_hand(vecs[3]);
        clear_counts();
        run_enabled(2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            deal_en  = 1'b0;
            new_hand = (i == 2);
            @(negedge slow_clock);
            chk($sformatf("stall.c%0d", i), strobe_sum() + int'(clr_hands), 0);
            @(posedge slow_clock);
            #1;
        end
        new_hand = 1'b0;
        deal_en  = 1'b1;
        #1;
        chk("stall.release", int'(load_pcard2), 1);
        run_enabled(12, 1'b0);
        check_hand("stall", vecs[3]);
        new_hand_seq("stall", 1'b1);

        // Asynchronous reset in S_D2 with deal_en high
        load_hand(vecs[2]);
        clear_counts();
        run_enabled(3, 1'b0);
        deal_en = 1'b1;
        #1;
        chk("midrst.in_d2", int'(load_dcard2), 1);
        resetb = 1'b0;
        #1;
        chk("midrst.strobes", strobe_sum() + int'(clr_hands), 0);
        chk("midrst.lights", int'(player_win_light) + int'(dealer_win_light), 0);
        tick();
        resetb = 1'b1;
        clear_counts();
        #1;
        chk("midrst.p1", int'(load_pcard1), 1);
        chk("midrst.no_d2", int'(load_dcard2), 0);
        run_enabled(12, 1'b0);
        check_hand("midrst", vecs[2]);
        new_hand_seq("midrst", 1'b0);

        // Random hands with random deal_en gaps against the hand model
        for (int i = 0; i < 30; i++) begin
            v = mk($urandom_range(1, 13), $urandom_range(1, 13), $urandom_range(1, 13),
                   $urandom_range(1, 13), $urandom_range(1, 13), $urandom_range(1, 13),
                   0, 0, 0, 0);
            v = model(v);
            play_hand($sformatf("rnd%0d", i), v, 1'b1, bit'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
